// File: rtl/branch_resolver.sv
// Branch resolver: resolves execute-stage control flow, offers a one-cycle-latency redirect and then holds a front-end flush.
// Redirect is held until the fetch handshake; define BRANCH_RESOLVER_STATS_EN to add resolve/mispredict counters.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evalid,
    input  logic        ebranch,
    input  logic        ejal,
    input  logic        ejalr,
    input  logic [2:0]  efunct3,
    input  logic [63:0] epc,
    input  logic [63:0] eimm,
    input  logic [63:0] ers1,
    input  logic        eeq,
    input  logic        elt,
    output logic        esignedComp,
    input  logic        epredTaken,
    input  logic [63:0] epredTarget,
    output logic        redirectValid,
    input  logic        redirectReady,
    output logic [63:0] redirectPc,
    output logic        flushFront,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [31:0] statsResolved,
    output logic [31:0] statsMispredicts,
`endif
    output logic        estall
);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [63:0] pc_q, pc_nxt;

    logic        is_ctrl;
    logic        cond_true;
    logic        taken;
    logic [63:0] jalr_sum;
    logic [63:0] target;
    logic [63:0] fall_through;
    logic        mispredict;
    logic        resolve;

    assign esignedComp = ~efunct3[1];

    always_comb begin
        cond_true = 1'b0;
        case (efunct3)
            3'b000:          cond_true = eeq;
            3'b001:          cond_true = ~eeq;
            3'b100, 3'b110:  cond_true = elt;
            3'b101, 3'b111:  cond_true = ~elt;
            default:         cond_true = 1'b0;
        endcase
    end

    assign is_ctrl      = ebranch | ejal | ejalr;
    assign taken        = ejal | ejalr | (ebranch & cond_true);
    assign jalr_sum     = ers1 + eimm;
    assign target       = ejalr ? {jalr_sum[63:1], 1'b0} : (epc + eimm);
    assign fall_through = epc + 64'd4;
    assign mispredict   = (taken != epredTaken) ||
                          (taken && epredTaken && (target != epredTarget));
    // Execute inputs only matter in IDLE; in other states they are wrong-path.
    assign resolve      = (state == IDLE) && evalid && is_ctrl;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_nxt        = pc_q;
        redirectValid = 1'b0;
        estall        = 1'b0;
        flushFront    = 1'b0;
        case (state)
            IDLE: begin
                if (resolve && mispredict) begin
                    state_nxt = REDIRECT;
                    pc_nxt    = taken ? target : fall_through;
                end else begin
                    pc_nxt = 64'd0;
                end
            end
            REDIRECT: begin
                redirectValid = 1'b1;
                estall        = 1'b1;
                flushFront    = 1'b1;
                if (redirectReady) begin
                    pc_nxt = 64'd0;
                    if (FLUSH_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FLUSH;
                        cnt_nxt   = 4'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                flushFront = 1'b1;
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                pc_nxt    = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            pc_q  <= 64'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pc_q  <= pc_nxt;
        end
    end

    assign redirectPc = pc_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            statsResolved    <= 32'd0;
            statsMispredicts <= 32'd0;
        end else begin
            if (resolve)
                statsResolved <= statsResolved + 32'd1;
            if (resolve && mispredict)
                statsMispredicts <= statsMispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles flushFront stays high after the redirect handshake; legal range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port evalid, input, 1 bit: an execute-stage instruction is present this cycle.
REQ-005 SHALL have ports ebranch, ejal, ejalr, inputs, 1 bit each: instruction class, one-hot or all zero.
REQ-006 SHALL have port efunct3, input, 3 bits: branch funct3.
REQ-007 SHALL have ports epc, eimm, ers1, inputs, 64 bits each: PC, sign-extended immediate, forwarded rs1.
REQ-008 SHALL have ports eeq, elt, inputs, 1 bit each: comparator equal / less-than results.
REQ-009 SHALL have port esignedComp, output, 1 bit: signedness select driven to the comparator.
REQ-010 SHALL have ports epredTaken (1 bit) and epredTarget (64 bits), inputs: fetch-stage prediction carried with the instruction.
REQ-011 SHALL have port redirectValid, output, 1 bit: a redirectPc is offered to fetch.
REQ-012 SHALL have port redirectReady, input, 1 bit: fetch accepts the redirect.
REQ-013 SHALL have port redirectPc, output, 64 bits: corrected fetch address.
REQ-014 SHALL have port flushFront, output, 1 bit: kill IF/ID contents.
REQ-015 SHALL have port estall, output, 1 bit: hold the execute stage.

Function
REQ-016 SHALL drive esignedComp = ~efunct3[1] combinationally in every state.
REQ-017 SHALL compute taken as: 000 eeq; 001 ~eeq; 100/110 elt; 101/111 ~elt; 010/011 not taken; ejal/ejalr always taken.
REQ-018 SHALL compute target as epc+eimm for branch/jal and (ers1+eimm) with bit0 cleared for jalr, using 64-bit modulo arithmetic; the fall-through address SHALL be epc+4, also modulo 2^64.
REQ-019 SHALL detect a mispredict when taken != epredTaken, or when taken and epredTaken are both 1 and target != epredTarget.
REQ-020 SHALL implement states IDLE, REDIRECT and FLUSH.
REQ-021 IDLE: when evalid is high, a class bit is set and a mispredict is detected, SHALL register redirectPc (target if taken, otherwise epc+4) and move to REDIRECT on the next edge.
REQ-022 IDLE: a correct prediction, a non-control instruction or evalid low SHALL leave the block in IDLE with all outputs deasserted.
REQ-023 REDIRECT: SHALL hold redirectValid=1, estall=1 and flushFront=1 with redirectPc stable until redirectValid and redirectReady are high in the same cycle.
REQ-024 On the handshake edge SHALL move to FLUSH with counter = FLUSH_CYCLES, or straight to IDLE when FLUSH_CYCLES=0.
REQ-025 FLUSH: SHALL hold flushFront=1, redirectValid=0 and estall=0, decrement the counter each cycle, and return to IDLE after FLUSH_CYCLES cycles.
REQ-026 In REDIRECT and FLUSH, SHALL ignore all execute inputs because they belong to the wrong path.
REQ-027 Redirect latency SHALL be exactly one cycle from the mispredicting execute cycle to redirectValid.
REQ-028 redirectReady while in IDLE or FLUSH SHALL have no effect.

Reset
REQ-029 rst SHALL force IDLE and a zero counter, and SHALL clear redirectValid, redirectPc, flushFront and estall (and stats counters when present) on the next edge.
REQ-030 rst SHALL take priority over every transition, including mid-REDIRECT and mid-FLUSH; no redirect survives reset.

Configuration
REQ-031 With macro BRANCH_RESOLVER_STATS_EN defined, SHALL add outputs statsResolved[31:0] (count of evalid control instructions resolved in IDLE) and statsMispredicts[31:0] (count of REQ-021 events), both wrapping at 2^32.
REQ-032 Without BRANCH_RESOLVER_STATS_EN, SHALL omit these ports and counters, with all other behaviour identical.

Verification
REQ-033 BEQ, epc=0x1000, eimm=0x40, eeq=1, epredTaken=0 -> next cycle redirectValid=1, redirectPc=0x1040, estall=1.
REQ-034 BLTU, efunct3=110 -> esignedComp=0; with elt=0 and epredTaken=0 -> no redirect, state stays IDLE.
REQ-035 JALR, ers1=0x2003, eimm=0x4, epredTaken=1, epredTarget=0x2000 -> redirectPc=0x2006.
REQ-036 Hold redirectReady=0 for 3 cycles, then 1 -> redirectValid held 4 cycles, then flushFront=1 for 2 more cycles, then IDLE.
REQ-037 BNE, epc=0xFFFF_FFFF_FFFF_FFFC, eeq=1, epredTaken=1 -> redirectPc=0x0 (wrap-around).
REQ-038 Assert rst in the second FLUSH cycle -> next cycle all outputs 0 and state IDLE; with stats enabled, both counters read 0.
